// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_if
// Description : Fetch bus, datapath strobes and ALU flags of instr_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if;
    logic        start;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instruction;
    logic        alu_en;
    logic        zero_flag;
    logic        eq_flag;
    logic        less_flag;
    logic        err_flag;
    logic        reg_we;
    logic [31:0] pc;
    logic        busy;
    logic        halted;
    logic [1:0]  fault_code;

    modport master (
        input  start, mem_ack, mem_rdata, zero_flag, eq_flag, less_flag, err_flag,
        output mem_req, mem_addr, instruction, alu_en, reg_we, pc, busy, halted, fault_code
    );

    modport slave (
        output start, mem_ack, mem_rdata, zero_flag, eq_flag, less_flag, err_flag,
        input  mem_req, mem_addr, instruction, alu_en, reg_we, pc, busy, halted, fault_code
    );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Multi-cycle fetch/execute/writeback controller for the CPU datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    instr_sequencer_if.master  bus
);
    localparam int                WAIT_W    = $clog2(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b01;
    localparam logic [1:0] FAULT_ALU      = 2'b10;
    localparam logic [1:0] FAULT_MISALIGN = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        fault_q, fault_d;
    logic              eq_q, eq_d;
    logic              less_q, less_d;
    logic              err_q, err_d;

    logic              mem_req_w;
    logic              alu_en_w;
    logic              reg_we_w;
    logic [6:0]        opcode_w;
    logic [2:0]        funct3_w;
    logic [31:0]       imm_w;
    logic [31:0]       target_w;
    logic [31:0]       pc_inc_w;
    logic              taken_w;
    logic              br_bad_w;

    assign opcode_w = instr_q[6:0];
    assign funct3_w = instr_q[14:12];
    assign imm_w    = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                       instr_q[30:25], instr_q[11:8], 1'b0};
    assign target_w = pc_q + imm_w;
    assign pc_inc_w = pc_q + 32'd4;

    // Branch condition from the flags captured in EXEC; funct3 010/011 is not a branch.
    always_comb begin
        taken_w  = 1'b0;
        br_bad_w = 1'b0;
        case (funct3_w)
            3'b000:         taken_w  = eq_q;
            3'b001:         taken_w  = !eq_q;
            3'b100, 3'b110: taken_w  = less_q;
            3'b101, 3'b111: taken_w  = !less_q;
            default:        br_bad_w = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            wait_q  <= '0;
            fault_q <= FAULT_NONE;
            eq_q    <= 1'b0;
            less_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            eq_q    <= eq_d;
            less_q  <= less_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        wait_d    = wait_q;
        fault_d   = fault_q;
        eq_d      = eq_q;
        less_d    = less_q;
        err_d     = err_q;
        mem_req_w = 1'b0;
        alu_en_w  = 1'b0;
        reg_we_w  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req_w = 1'b1;
                if (bus.mem_ack) begin
                    instr_d = bus.mem_rdata;
                    wait_d  = '0;
                    state_d = S_EXEC;
                end else if (wait_q == WAIT_LAST) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_EXEC: begin
                alu_en_w = 1'b1;
                eq_d     = bus.eq_flag;
                less_d   = bus.less_flag;
                err_d    = bus.err_flag;
                state_d  = S_WB;
            end
            S_WB: begin
                if (err_q) begin
                    fault_d = FAULT_ALU;
                    state_d = S_HALT;
                end else if (opcode_w == OPC_BRANCH) begin
                    if (br_bad_w) begin
                        fault_d = FAULT_ALU;
                        state_d = S_HALT;
                    end else if (taken_w && (target_w[1:0] != 2'b00)) begin
                        fault_d = FAULT_MISALIGN;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = taken_w ? target_w : pc_inc_w;
                        state_d = S_FETCH;
                    end
                end else begin
                    reg_we_w = (opcode_w == OPC_OP) || (opcode_w == OPC_OPIMM);
                    pc_d     = pc_inc_w;
                    state_d  = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes decode straight from the state register so an async reset drops them at once.
    assign bus.mem_req     = mem_req_w;
    assign bus.mem_addr    = pc_q;
    assign bus.instruction = instr_q;
    assign bus.alu_en      = alu_en_w;
    assign bus.reg_we      = reg_we_w;
    assign bus.pc          = pc_q;
    assign bus.busy        = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_WB);
    assign bus.halted      = (state_q == S_HALT);
    assign bus.fault_code  = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Scoreboard bench for instr_sequencer: fetch and halt events vs. expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instr_sequencer_if bus ();

    instr_sequencer #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:15];
    logic        ack_force = 1'b0;
    assign bus.mem_ack   = ack_force;
    assign bus.mem_rdata = mem[bus.mem_addr[5:2]];

    typedef struct {
        bit          is_halt;
        logic [31:0] addr;
        logic [1:0]  fault;
        logic [31:0] instr;
        int          we;
        int          gap;
        int          req;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_fetch(input logic [31:0] addr, input int we, input int gap);
        exp_t e;
        e.is_halt = 1'b0; e.addr = addr; e.fault = 2'b00; e.instr = 32'h0;
        e.we = we; e.gap = gap; e.req = -1;
        sb.push_back(e);
    endtask

    task automatic push_halt(input logic [1:0] fault, input logic [31:0] pc,
                             input logic [31:0] instr, input int req);
        exp_t e;
        e.is_halt = 1'b1; e.addr = pc; e.fault = fault; e.instr = instr;
        e.we = 0; e.gap = 0; e.req = req;
        sb.push_back(e);
    endtask

    // Monitor: a rising mem_req or rising halted is one observable event.
    bit   prev_req  = 1'b0;
    bit   prev_halt = 1'b0;
    int   we_cnt    = 0;
    int   req_cnt   = 0;
    int   cyc       = 0;
    int   last_ev   = 0;
    exp_t m_e;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                we_cnt = 0; req_cnt = 0; prev_req = 1'b0; prev_halt = 1'b0; last_ev = cyc;
                continue;
            end
            if (bus.reg_we)  we_cnt++;
            if (bus.mem_req) req_cnt++;
            if ((bus.mem_req && !prev_req) || (bus.halted && !prev_halt)) begin
                if (sb.size() != 0) begin
                    m_e = sb.pop_front();
                    chk("event kind halted", {31'h0, bus.halted}, {31'h0, m_e.is_halt});
                    chk("reg_we pulses", we_cnt, m_e.we);
                    if (m_e.gap > 0) chk("fetch spacing", cyc - last_ev, m_e.gap);
                    if (m_e.is_halt) begin
                        chk("halt fault_code", {30'h0, bus.fault_code}, {30'h0, m_e.fault});
                        chk("halt pc", bus.pc, m_e.addr);
                        chk("halt instruction", bus.instruction, m_e.instr);
                        chk("halt mem_req/busy", {30'h0, bus.mem_req, bus.busy}, 32'h0);
                        if (m_e.req >= 0) chk("req cycles before halt", req_cnt, m_e.req);
                    end else begin
                        chk("fetch mem_addr", bus.mem_addr, m_e.addr);
                    end
                end
                we_cnt = 0; req_cnt = 0; last_ev = cyc;
            end
            prev_req  = bus.mem_req;
            prev_halt = bus.halted;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("reset mem_req", {31'h0, bus.mem_req}, 32'h0);
        chk("reset busy/halted", {30'h0, bus.busy, bus.halted}, 32'h0);
        chk("reset pc", bus.pc, 32'h0);
        chk("reset instruction", bus.instruction, 32'h0);
        chk("reset fault_code", {30'h0, bus.fault_code}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    endtask

    task automatic set_flags(input logic eq, input logic less, input logic err);
        bus.eq_flag = eq; bus.less_flag = less; bus.err_flag = err;
    endtask

    task automatic kick();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("scoreboard drain timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit found;
        bus.start = 1'b0;
        bus.zero_flag = 1'b0;
        set_flags(1'b0, 1'b0, 1'b0);
        clear_mem();

        // Straight-line ALU ops: reg_we once per OP/OP-IMM, fetch every 3rd cycle.
        ack_force = 1'b1;
        mem[0] = 32'h0091_1313; mem[1] = 32'h0091_1313; mem[2] = 32'h0020_81b3;
        do_reset();
        push_fetch(32'h00, 0, 0); push_fetch(32'h04, 1, 3); push_fetch(32'h08, 1, 3);
        push_fetch(32'h0C, 1, 3); push_fetch(32'h10, 0, 3);
        kick();
        drain(100);

        // beq +8 at 0x10, taken and not taken.
        clear_mem();
        mem[4] = 32'h0000_0463;
        set_flags(1'b1, 1'b0, 1'b0);
        do_reset();
        push_fetch(32'h00, 0, 0); push_fetch(32'h04, 0, 3); push_fetch(32'h08, 0, 3);
        push_fetch(32'h0C, 0, 3); push_fetch(32'h10, 0, 3); push_fetch(32'h18, 0, 3);
        kick();
        drain(100);
        set_flags(1'b0, 1'b0, 1'b0);
        do_reset();
        push_fetch(32'h00, 0, 0); push_fetch(32'h04, 0, 3); push_fetch(32'h08, 0, 3);
        push_fetch(32'h0C, 0, 3); push_fetch(32'h10, 0, 3); push_fetch(32'h14, 0, 3);
        kick();
        drain(100);

        // Fetch timeout, then a late ack must not disturb HALT.
        clear_mem();
        ack_force = 1'b0;
        do_reset();
        push_fetch(32'h00, 0, 0);
        push_halt(2'b01, 32'h0, 32'h0, 15);
        kick();
        drain(100);
        ack_force = 1'b1;
        repeat (3) @(negedge clk);
        chk("late ack halted", {31'h0, bus.halted}, 32'h1);
        chk("late ack fault_code", {30'h0, bus.fault_code}, 32'h1);
        chk("late ack instruction", bus.instruction, 32'h0);

        // ALU error on an OP-IMM instruction.
        mem[0] = 32'h0091_1313;
        set_flags(1'b0, 1'b0, 1'b1);
        do_reset();
        push_fetch(32'h00, 0, 0);
        push_halt(2'b10, 32'h0, 32'h0091_1313, -1);
        kick();
        drain(100);

        // Taken beq to pc+6 -> misaligned fault.
        clear_mem();
        mem[0] = 32'h0000_0363;
        set_flags(1'b1, 1'b0, 1'b0);
        do_reset();
        push_fetch(32'h00, 0, 0);
        push_halt(2'b11, 32'h0, 32'h0000_0363, -1);
        kick();
        drain(100);

        // Not-taken bne with the same offset -> pc+4.
        mem[0] = 32'h0000_1363;
        do_reset();
        push_fetch(32'h00, 0, 0); push_fetch(32'h04, 0, 3);
        kick();
        drain(100);

        // blt taken (+8) then bge not taken, both on less_flag=1.
        clear_mem();
        mem[0] = 32'h0000_4463; mem[2] = 32'h0000_5463;
        set_flags(1'b0, 1'b1, 1'b0);
        do_reset();
        push_fetch(32'h00, 0, 0); push_fetch(32'h08, 0, 3); push_fetch(32'h0C, 0, 3);
        kick();
        drain(100);

        // Reserved branch funct3 halts with the ALU fault.
        clear_mem();
        mem[0] = 32'h0000_2463;
        do_reset();
        push_fetch(32'h00, 0, 0);
        push_halt(2'b10, 32'h0, 32'h0000_2463, -1);
        kick();
        drain(100);

        // Async reset while stalled in FETCH at pc=8.
        clear_mem();
        set_flags(1'b0, 1'b0, 1'b0);
        do_reset();
        kick();
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (bus.mem_req && bus.mem_addr == 32'h8) begin
                ack_force = 1'b0;
                found = 1'b1;
            end
        end
        chk("reach stalled fetch at 8", {31'h0, found}, 32'h1);
        repeat (2) @(negedge clk);
        chk("stalled pc before reset", bus.pc, 32'h8);
        #3 rst = 1'b1;
        #1;
        chk("async reset mem_req", {31'h0, bus.mem_req}, 32'h0);
        chk("async reset busy", {31'h0, bus.busy}, 32'h0);
        chk("async reset pc", bus.pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ack_force = 1'b1;
        push_fetch(32'h00, 0, 0); push_fetch(32'h04, 0, 3);
        kick();
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
